// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry (main + skid) pipeline register with valid/ready
// handshake on both sides, flush, and a registered up_ready.
// Optional feature: define PIPE_STALL_CNT_EN to build a saturating
// backpressure counter on stall_cnt. Otherwise stall_cnt is tied to 0.
module pipe_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [31:0]       up_pc,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [4:0]        up_rd,
  input  logic [XLEN-1:0]   up_data,
  input  logic              flush,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [31:0]       dn_pc,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [4:0]        dn_rd,
  output logic [XLEN-1:0]   dn_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_nxt;
  logic              rdy_q;
  logic              accept;
  logic              release_w;
  logic              load_main;
  logic              load_skid;
  logic              move_skid;

  logic [31:0]       main_pc_p0;
  logic [CTRL_W-1:0] main_ctrl_p0;
  logic [4:0]        main_rd_p0;
  logic [XLEN-1:0]   main_data_p0;
  logic [31:0]       skid_pc_p0;
  logic [CTRL_W-1:0] skid_ctrl_p0;
  logic [4:0]        skid_rd_p0;
  logic [XLEN-1:0]   skid_data_p0;

  // rdy_q holds "not full" from the previous edge; gating with rst_n keeps
  // the stage from accepting while reset is held.
  assign up_ready  = rdy_q & rst_n;
  assign dn_valid  = (state_q != ST_EMPTY);
  assign occ       = state_q;
  assign accept    = up_valid & up_ready;
  assign release_w = dn_valid & dn_ready;

  // Bubbles must never carry write enables downstream.
  assign dn_pc   = main_pc_p0;
  assign dn_ctrl = main_ctrl_p0 & {CTRL_W{dn_valid}};
  assign dn_rd   = main_rd_p0;
  assign dn_data = main_data_p0;

  // Next-state and payload-steering decode.
  always_comb begin
    state_nxt = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_main = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && release_w) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end else if (release_w) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (release_w) begin
            move_skid = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Control state and registered ready.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_nxt;
      rdy_q   <= (state_nxt != ST_FULL);
    end
  end

  // ---- stage p0: main / skid payload storage ----
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      main_pc_p0   <= '0;
      main_ctrl_p0 <= '0;
      main_rd_p0   <= '0;
      main_data_p0 <= '0;
      skid_pc_p0   <= '0;
      skid_ctrl_p0 <= '0;
      skid_rd_p0   <= '0;
      skid_data_p0 <= '0;
    end else begin
      if (load_main) begin
        main_pc_p0   <= up_pc;
        main_ctrl_p0 <= up_ctrl;
        main_rd_p0   <= up_rd;
        main_data_p0 <= up_data;
      end else if (move_skid) begin
        main_pc_p0   <= skid_pc_p0;
        main_ctrl_p0 <= skid_ctrl_p0;
        main_rd_p0   <= skid_rd_p0;
        main_data_p0 <= skid_data_p0;
      end
      if (load_skid) begin
        skid_pc_p0   <= up_pc;
        skid_ctrl_p0 <= up_ctrl;
        skid_rd_p0   <= up_rd;
        skid_data_p0 <= up_data;
      end
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + 1'b1;
  endfunction

  // Count cycles an entry is presented but refused; sticks at all-ones.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (dn_valid && !dn_ready && !flush) begin
      stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg (XLEN=32, CTRL_W=4, CNT_W=4).
module tb_pipe_stage_reg;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] up_pc;
  logic [3:0]  up_ctrl;
  logic [4:0]  up_rd;
  logic [31:0] up_data;
  logic        flush;
  logic        dn_valid;
  logic        dn_ready;
  logic [31:0] dn_pc;
  logic [3:0]  dn_ctrl;
  logic [4:0]  dn_rd;
  logic [31:0] dn_data;
  logic [1:0]  occ;
  logic [3:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

`ifdef PIPE_STALL_CNT_EN
  localparam logic [3:0] STALL_SAT = 4'd15;
`else
  localparam logic [3:0] STALL_SAT = 4'd0;
`endif

  pipe_stage_reg #(.XLEN(32), .CTRL_W(4), .CNT_W(4)) dut (
    .CLK(CLK), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready),
    .up_pc(up_pc), .up_ctrl(up_ctrl), .up_rd(up_rd), .up_data(up_data),
    .flush(flush),
    .dn_valid(dn_valid), .dn_ready(dn_ready),
    .dn_pc(dn_pc), .dn_ctrl(dn_ctrl), .dn_rd(dn_rd), .dn_data(dn_data),
    .occ(occ), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [3:0] ctrl);
    up_valid = v;
    up_pc    = pc;
    up_ctrl  = ctrl;
    up_rd    = pc[6:2];
    up_data  = ~pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; dn_ready = 1'b0;
    offer(1'b0, 32'h0, 4'h0);

    // Reset state
    step(); step();
    check_val("rst_up_ready", up_ready, 0);
    check_val("rst_occ", occ, 0);
    check_val("rst_dn_valid", dn_valid, 0);
    check_val("rst_dn_pc", dn_pc, 0);
    check_val("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_up_ready", up_ready, 1);
    check_val("post_rst_dn_valid", dn_valid, 0);
    check_val("post_rst_dn_ctrl", dn_ctrl, 0);
    check_val("post_rst_occ", occ, 0);

    // First transfer, 1-cycle latency
    dn_ready = 1'b1;
    offer(1'b1, 32'h100, 4'b0001);
    step();
    check_val("lat_dn_valid", dn_valid, 1);
    check_val("lat_dn_pc", dn_pc, 32'h100);
    check_val("lat_dn_ctrl", dn_ctrl, 4'b0001);
    check_val("lat_dn_rd", dn_rd, 5'h00);
    check_val("lat_dn_data", dn_data, ~32'h100);
    check_val("lat_occ", occ, 1);
    offer(1'b0, 32'h0, 4'h0);
    step();
    check_val("drain_occ", occ, 0);
    check_val("drain_dn_ctrl_masked", dn_ctrl, 0);

    // Skid fill under backpressure, then ordered drain
    dn_ready = 1'b0;
    offer(1'b1, 32'h10, 4'b0011);
    step();
    check_val("skid_a_occ", occ, 1);
    check_val("skid_a_up_ready", up_ready, 1);
    offer(1'b1, 32'h14, 4'b1000);
    step();
    check_val("skid_full_occ", occ, 2);
    check_val("skid_full_up_ready", up_ready, 0);
    check_val("skid_full_dn_pc", dn_pc, 32'h10);
    check_val("skid_full_dn_ctrl", dn_ctrl, 4'b0011);
    offer(1'b1, 32'h18, 4'b0001);
    step();
    check_val("skid_hold_occ", occ, 2);
    check_val("skid_hold_dn_pc", dn_pc, 32'h10);
    offer(1'b0, 32'h0, 4'h0);
    dn_ready = 1'b1;
    step();
    check_val("skid_rel1_dn_pc", dn_pc, 32'h14);
    check_val("skid_rel1_dn_ctrl", dn_ctrl, 4'b1000);
    check_val("skid_rel1_up_ready", up_ready, 1);
    check_val("skid_rel1_occ", occ, 1);
    step();
    check_val("skid_rel2_occ", occ, 0);
    check_val("skid_rel2_dn_valid", dn_valid, 0);

    // Streaming at full rate
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, 32'h200 + 32'(4 * i), 4'b0001);
      step();
      check_val($sformatf("stream%0d_valid", i), dn_valid, 1);
      check_val($sformatf("stream%0d_pc", i), dn_pc, 32'h200 + 32'(4 * i));
      check_val($sformatf("stream%0d_occ", i), occ, 1);
    end
    offer(1'b0, 32'h0, 4'h0);
    step();
    check_val("stream_end_valid", dn_valid, 0);

    // Stall counter saturation and payload hold
    dn_ready = 1'b0;
    offer(1'b1, 32'h300, 4'b0101);
    step();
    offer(1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 20; i++) step();
    check_val("stall_sat", stall_cnt, STALL_SAT);
    check_val("stall_hold_pc", dn_pc, 32'h300);
    check_val("stall_hold_ctrl", dn_ctrl, 4'b0101);

    // Flush from FULL with a same-cycle offer
    offer(1'b1, 32'h304, 4'b0001);
    step();
    check_val("flush_pre_occ", occ, 2);
    flush = 1'b1;
    offer(1'b1, 32'h308, 4'b0001);
    step();
    check_val("flush_dn_valid", dn_valid, 0);
    check_val("flush_dn_ctrl", dn_ctrl, 0);
    check_val("flush_occ", occ, 0);
    check_val("flush_up_ready", up_ready, 1);
    flush = 1'b0;
    offer(1'b0, 32'h0, 4'h0);
    dn_ready = 1'b1;
    step();
    check_val("flush_no_deliver", dn_valid, 0);
    check_val("flush_stall_kept", stall_cnt, STALL_SAT);

    // Reset dominates flush in FULL state
    dn_ready = 1'b0;
    offer(1'b1, 32'h400, 4'b0001);
    step();
    offer(1'b1, 32'h404, 4'b0001);
    step();
    check_val("rstfull_pre_occ", occ, 2);
    rst_n = 1'b0; flush = 1'b1; dn_ready = 1'b1;
    offer(1'b1, 32'h408, 4'b0001);
    step();
    check_val("rstfull_occ", occ, 0);
    check_val("rstfull_dn_valid", dn_valid, 0);
    check_val("rstfull_dn_pc", dn_pc, 0);
    check_val("rstfull_dn_ctrl", dn_ctrl, 0);
    check_val("rstfull_dn_rd", dn_rd, 0);
    check_val("rstfull_dn_data", dn_data, 0);
    check_val("rstfull_up_ready", up_ready, 0);
    check_val("rstfull_stall", stall_cnt, 0);
    rst_n = 1'b1; flush = 1'b0;
    offer(1'b0, 32'h0, 4'h0);
    step();
    check_val("rstfull_after_occ", occ, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
